afe_config_sequencer: RTL
=========================

AFE_CONFIG_SEQUENCER -- requirements
Module: afe_config_sequencer

Interface
REQ-001 The block SHALL have these parameters:
- NUM_DEVICES, default 2, number of AFE chips sharing mosi/sclk, each with its own chip select.
- CMD_WIDTH, default 24, serial command length in bits.
- DATA_W, default 8, width of the readback compare field.
- ROM_DEPTH, default 256, number of command words addressable.
- SCLK_HALF, default 4, sclk half-period in clk cycles, minimum 2.
- RESET_CYCLES, default 64, device_reset pulse width.
- RESET_WAIT, default 256, cycles from reset release to the first transaction.
- SYNC_CYCLES, default 4, device_sync pulse width.
- MAX_RETRY, default 3, readback retries per command.

REQ-002 DEV_W SHALL be max(1, clog2(NUM_DEVICES)); AW SHALL be clog2(ROM_DEPTH); ROM_W SHALL be CMD_WIDTH+DEV_W+2.

REQ-003 The block SHALL have these ports:
- clk, input, 1: single clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: one-cycle pulse that restarts the full configuration sequence.
- rom_address, output, AW: command ROM address.
- rom_command, input, ROM_W: ROM data, valid one clk after rom_address.
- device_reset, output, 1: active-high AFE reset.
- pdn, output, 1: AFE power-down, constant 0.
- cs_n, output, NUM_DEVICES: active-low chip selects.
- sclk, output, 1: serial clock.
- mosi, output, 1: serial data out.
- miso, input, 1: serial data in.
- device_sync, output, 1: synchronisation pulse.
- configure_done, output, 1: configuration completed without error.
- error, output, 1: readback retries exhausted.
- busy, output, 1: sequence in progress.

REQ-004 The rom_command word SHALL be {last, verify, dev[DEV_W-1:0], cmd[CMD_WIDTH-1:0]}.

Function
REQ-005 The states SHALL be IDLE, RST_PULSE, RST_WAIT, FETCH, SHIFT, GAP, SYNC, DONE and ERR.

REQ-006 On exit from reset the block SHALL enter RST_PULSE automatically; start SHALL re-enter RST_PULSE from IDLE, DONE or ERR and SHALL be ignored in every other state.

REQ-007 In RST_PULSE the block SHALL hold device_reset=1 for exactly RESET_CYCLES clks, then go to RST_WAIT.

REQ-008 In RST_WAIT the block SHALL count RESET_WAIT clks with rom_address=0, then go to FETCH.

REQ-009 FETCH SHALL take 2 clks (ROM latency), latch rom_command, and clear the bit counter.

REQ-010 SHIFT timing SHALL be as follows:
- cs_n[dev] goes low, with mosi = cmd[CMD_WIDTH-1], SCLK_HALF clks before the first sclk rising edge.
- The block sends exactly CMD_WIDTH sclk pulses, MSB first.
- mosi changes only on sclk falling edges; miso is sampled on sclk rising edges into a CMD_WIDTH shift register.

REQ-011 After the last falling edge, cs_n SHALL rise SCLK_HALF clks later, and the block SHALL hold all cs_n high for a 2*SCLK_HALF clk GAP state.

REQ-012 If dev >= NUM_DEVICES, no cs_n bit SHALL assert, but timing SHALL be unchanged.

REQ-013 On GAP exit with verify=1:
- If captured[DATA_W-1:0] differs from cmd[DATA_W-1:0] and the retry count is below MAX_RETRY, the retry count increments and the same word is reshifted (no FETCH).
- If they differ and the retry count equals MAX_RETRY, the block goes to ERR.

REQ-014 On GAP exit with verify=0, or with verify=1 and a match:
- The retry count SHALL clear.
- If last=1 or rom_address=ROM_DEPTH-1, the block goes to SYNC.
- Otherwise rom_address increments by 1 and the block goes to FETCH.
- rom_address SHALL never wrap.

REQ-015 In SYNC the block SHALL hold device_sync=1 for exactly SYNC_CYCLES clks, then go to DONE.

REQ-016 In DONE, configure_done SHALL be 1 and busy 0.

REQ-017 In ERR, error SHALL be 1, configure_done 0, busy 0, all cs_n high, and device_sync never asserted.

REQ-018 busy SHALL be 1 in every state except IDLE, DONE and ERR; sclk SHALL be 0 and all cs_n 1 outside SHIFT.

REQ-019 On start from DONE or ERR, configure_done and error SHALL clear in the same cycle the block enters RST_PULSE.

Reset
REQ-020 While reset=1 the outputs SHALL be:
- device_reset=0, cs_n=all 1, sclk=0, mosi=0.
- device_sync=0, configure_done=0, error=0, busy=0.
- rom_address=0, all counters 0, state IDLE.

REQ-021 Reset asserted mid-transaction SHALL abort the transaction in the next cycle, with cs_n high and no further sclk edges.

REQ-022 The first clk with reset=0 SHALL enter RST_PULSE.

Verification
REQ-023 Default parameters; ROM holds 3 write words, the third with last=1. Required response:
- device_reset high for 64 clks.
- First cs_n fall 256 clks after device_reset falls.
- 3 frames of 24 sclk pulses each.
- One 4-clk device_sync pulse, then configure_done=1.

REQ-024 Word with dev=1 and cmd=0xA5_3C_0F: cs_n=2'b01 throughout the frame, and the mosi bit sequence equals 0xA53C0F MSB first.

REQ-025 Verify word with cmd[7:0]=0x5A and miso returning 0x5A: exactly 1 frame is sent, and the sequence continues to the next address.

REQ-026 Verify word with miso always returning 0x00: exactly 4 frames (1 + MAX_RETRY) are sent, then error=1, configure_done=0 and no device_sync pulse.

REQ-027 Reset pulse at sclk pulse 10 of a frame: cs_n high and outputs at reset values next clk; after release the sequence restarts from address 0.

REQ-028 ROM with no last bit set and ROM_DEPTH=4: exactly 4 frames are sent, rom_address stops at 3, then SYNC and DONE.

Source files
------------

// File: rtl/afe_config_sequencer.sv
// afe_config_sequencer
//
// Brings a group of AFE chips out of reset and programs them from a command
// ROM over a shared serial bus. The sequence is: reset pulse, settle wait,
// then one serial frame per ROM word until a word marked "last" (or the top
// of the ROM) is reached, then a sync pulse. Words marked "verify" are
// read back and reshifted up to MAX_RETRY times before giving up.
//
// Ports
//   clk            : single clock, everything on the rising edge
//   reset          : synchronous active-high reset
//   start          : one-cycle pulse, restarts the sequence from IDLE/DONE/ERR
//   rom_address    : command ROM address (registered ROM, 1 clk latency)
//   rom_command    : {last, verify, dev, cmd}
//   device_reset   : active-high AFE reset pulse
//   pdn            : AFE power-down, tied low
//   cs_n           : active-low chip select per device
//   sclk, mosi     : serial clock / data out
//   miso           : serial data in
//   device_sync    : synchronisation pulse after a clean configuration
//   configure_done : sequence finished without error
//   error          : readback retries exhausted
//   busy           : sequence in progress
module afe_config_sequencer #(
    parameter int NUM_DEVICES  = 2,
    parameter int CMD_WIDTH    = 24,
    parameter int DATA_W       = 8,
    parameter int ROM_DEPTH    = 256,
    parameter int SCLK_HALF    = 4,
    parameter int RESET_CYCLES = 64,
    parameter int RESET_WAIT   = 256,
    parameter int SYNC_CYCLES  = 4,
    parameter int MAX_RETRY    = 3,
    localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1,
    localparam int AW    = $clog2(ROM_DEPTH),
    localparam int ROM_W = CMD_WIDTH + DEV_W + 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [AW-1:0]          rom_address,
    input  logic [ROM_W-1:0]       rom_command,
    output logic                   device_reset,
    output logic                   pdn,
    output logic [NUM_DEVICES-1:0] cs_n,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic                   device_sync,
    output logic                   configure_done,
    output logic                   error,
    output logic                   busy
);

    // The settle wait is shortened by the two FETCH cycles so that the first
    // chip select falls exactly RESET_WAIT clks after device_reset drops.
    localparam int WAIT_LEN  = (RESET_WAIT > 2) ? RESET_WAIT - 2 : 1;
    localparam int GAP_LEN   = 2 * SCLK_HALF;
    localparam int MAX_A     = (RESET_CYCLES > WAIT_LEN) ? RESET_CYCLES : WAIT_LEN;
    localparam int MAX_B     = (GAP_LEN > SYNC_CYCLES) ? GAP_LEN : SYNC_CYCLES;
    localparam int MAX_CNT   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W     = $clog2(MAX_CNT + 1);
    // A frame is 2*CMD_WIDTH+1 half periods: a leading low half, then one
    // high and one low half per bit.
    localparam int LAST_HALF = 2 * CMD_WIDTH;
    localparam int HALF_W    = $clog2(LAST_HALF + 2);
    localparam int RETRY_W   = $clog2(MAX_RETRY + 2);

    typedef enum logic [3:0] {
        IDLE, RST_PULSE, RST_WAIT, FETCH, SHIFT, GAP, SYNC, DONE, ERR
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     count;
    logic [HALF_W-1:0]    half;
    logic [RETRY_W-1:0]   retry;
    logic [CMD_WIDTH-1:0] cmd_reg;
    logic [CMD_WIDTH-1:0] tx_shift;
    logic [DEV_W-1:0]     dev_reg;
    logic                 verify_reg;
    logic                 last_reg;
    logic [DATA_W-1:0]    captured;
    logic                 boot_pending;

    logic tick_last;
    logic on_last_half;
    logic mismatch;
    logic retry_left;
    logic at_end;

    // Only the low DATA_W bits of the readback are ever compared, so the
    // capture register keeps just the most recent DATA_W miso samples.
    assign tick_last    = (count == CNT_W'(SCLK_HALF - 1));
    assign on_last_half = (half == HALF_W'(LAST_HALF));
    assign mismatch     = (captured != cmd_reg[DATA_W-1:0]);
    assign retry_left   = (retry < RETRY_W'(MAX_RETRY));
    assign at_end       = last_reg || (rom_address == AW'(ROM_DEPTH - 1));
    assign pdn          = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        device_reset   = 1'b0;
        device_sync    = 1'b0;
        configure_done = 1'b0;
        error          = 1'b0;
        busy           = 1'b1;
        sclk           = 1'b0;
        mosi           = 1'b0;
        cs_n           = '1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start || boot_pending) state_next = RST_PULSE;
            end
            RST_PULSE: begin
                device_reset = 1'b1;
                if (count == CNT_W'(RESET_CYCLES - 1)) state_next = RST_WAIT;
            end
            RST_WAIT: begin
                if (count == CNT_W'(WAIT_LEN - 1)) state_next = FETCH;
            end
            FETCH: begin
                if (count == CNT_W'(1)) state_next = SHIFT;
            end
            SHIFT: begin
                sclk = half[0];
                mosi = tx_shift[CMD_WIDTH-1];
                // Out-of-range device numbers still clock a full frame but
                // select nobody.
                for (int i = 0; i < NUM_DEVICES; i++) begin
                    if (dev_reg == DEV_W'(i)) cs_n[i] = 1'b0;
                end
                if (tick_last && on_last_half) state_next = GAP;
            end
            GAP: begin
                if (count == CNT_W'(GAP_LEN - 1)) begin
                    if (verify_reg && mismatch) begin
                        state_next = retry_left ? SHIFT : ERR;
                    end else begin
                        state_next = at_end ? SYNC : FETCH;
                    end
                end
            end
            SYNC: begin
                device_sync = 1'b1;
                if (count == CNT_W'(SYNC_CYCLES - 1)) state_next = DONE;
            end
            DONE: begin
                busy           = 1'b0;
                configure_done = 1'b1;
                if (start) state_next = RST_PULSE;
            end
            ERR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) state_next = RST_PULSE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: phase counter, half-period counter, retry/address tracking,
    // command latch, transmit shifter and readback capture. The phase counter
    // restarts on every state change and, inside SHIFT, on every half period.
    always_ff @(posedge clk) begin
        if (reset) begin
            boot_pending <= 1'b1;
            count        <= '0;
            half         <= '0;
            retry        <= '0;
            rom_address  <= '0;
            cmd_reg      <= '0;
            tx_shift     <= '0;
            dev_reg      <= '0;
            verify_reg   <= 1'b0;
            last_reg     <= 1'b0;
            captured     <= '0;
        end else begin
            boot_pending <= 1'b0;

            if (state_next != state || state == IDLE || state == DONE ||
                state == ERR || (state == SHIFT && tick_last)) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end

            if (state != SHIFT) begin
                half <= '0;
            end else if (tick_last) begin
                half <= half + 1'b1;
            end

            if (state != RST_PULSE && state_next == RST_PULSE) begin
                rom_address <= '0;
                retry       <= '0;
            end else if (state == GAP && state_next == SHIFT) begin
                retry <= retry + 1'b1;
            end else if (state == GAP && state_next == FETCH) begin
                retry       <= '0;
                rom_address <= rom_address + 1'b1;
            end else if (state == GAP && state_next == SYNC) begin
                retry <= '0;
            end

            // mosi advances only at the end of a high half, i.e. on sclk falls.
            if (state == FETCH && state_next == SHIFT) begin
                {last_reg, verify_reg, dev_reg, cmd_reg} <= rom_command;
                tx_shift <= rom_command[CMD_WIDTH-1:0];
            end else if (state == GAP && state_next == SHIFT) begin
                tx_shift <= cmd_reg;
            end else if (state == SHIFT && tick_last && half[0]) begin
                tx_shift <= CMD_WIDTH'({tx_shift, 1'b0});
            end

            // miso is sampled on the clk edge where sclk goes high.
            if (state == SHIFT && tick_last && !half[0] && !on_last_half) begin
                captured <= DATA_W'({captured, miso});
            end
        end
    end

endmodule
